// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, ALU-side and result-side signals around alu_share_arbiter.
// master = requesters / ALU / consumer side, slave = the arbiter itself.
interface alu_share_arbiter_if #(
    parameter int NumReq       = 2,
    parameter int XLEN         = 64,
    parameter int OpWidth      = 8,
    parameter int TransIdWidth = 3
) ();
    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic                           flush_i;
    logic [NumReq-1:0]              req_valid_i;
    logic [NumReq-1:0]              req_ready_o;
    logic [NumReq*OpWidth-1:0]      req_op_i;
    logic [NumReq*XLEN-1:0]         req_operand_a_i;
    logic [NumReq*XLEN-1:0]         req_operand_b_i;
    logic [NumReq*TransIdWidth-1:0] req_trans_id_i;
    logic                           alu_valid_o;
    logic [OpWidth-1:0]             alu_op_o;
    logic [XLEN-1:0]                alu_operand_a_o;
    logic [XLEN-1:0]                alu_operand_b_o;
    logic [XLEN-1:0]                alu_result_i;
    logic                           alu_branch_res_i;
    logic                           out_valid_o;
    logic                           out_ready_i;
    logic [IdxW-1:0]                out_req_idx_o;
    logic [TransIdWidth-1:0]        out_trans_id_o;
    logic [XLEN-1:0]                out_result_o;
    logic                           out_branch_res_o;

    modport master (
        output flush_i, req_valid_i, req_op_i, req_operand_a_i, req_operand_b_i,
               req_trans_id_i, alu_result_i, alu_branch_res_i, out_ready_i,
        input  req_ready_o, alu_valid_o, alu_op_o, alu_operand_a_o, alu_operand_b_o,
               out_valid_o, out_req_idx_o, out_trans_id_o, out_result_o, out_branch_res_o
    );

    modport slave (
        input  flush_i, req_valid_i, req_op_i, req_operand_a_i, req_operand_b_i,
               req_trans_id_i, alu_result_i, alu_branch_res_i, out_ready_i,
        output req_ready_o, alu_valid_o, alu_op_o, alu_operand_a_o, alu_operand_b_o,
               out_valid_o, out_req_idx_o, out_trans_id_o, out_result_o, out_branch_res_o
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU among NumReq issue ports, with a single-entry
// valid/ready result buffer. Define ALU_ARB_PERF_EN to add grant/stall counters.
module alu_share_arbiter #(
    parameter int NumReq       = 2,
    parameter int XLEN         = 64,
    parameter int OpWidth      = 8,
    parameter int TransIdWidth = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    alu_share_arbiter_if.slave   bus
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [NumReq*32-1:0] perf_grant_cnt_o,
    output logic [31:0]          perf_stall_cnt_o
`endif
);
    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [OpWidth-1:0]      op_arr_s  [NumReq];
    logic [XLEN-1:0]         a_arr_s   [NumReq];
    logic [XLEN-1:0]         b_arr_s   [NumReq];
    logic [TransIdWidth-1:0] tid_arr_s [NumReq];

    logic [IdxW-1:0]         rr_q, rr_d;
    logic                    out_valid_q, out_valid_d;
    logic [IdxW-1:0]         out_req_idx_q, out_req_idx_d;
    logic [TransIdWidth-1:0] out_trans_id_q, out_trans_id_d;
    logic [XLEN-1:0]         out_result_q, out_result_d;
    logic                    out_branch_res_q, out_branch_res_d;

    logic                    grant_en_s;
    logic                    gnt_found_s;
    logic [IdxW-1:0]         gnt_idx_s;
    logic [IdxW-1:0]         cand_s;
    logic [NumReq-1:0]       gnt_vec_s;
    logic [OpWidth-1:0]      alu_op_s;
    logic [XLEN-1:0]         alu_a_s;
    logic [XLEN-1:0]         alu_b_s;

    for (genvar i = 0; i < NumReq; i++) begin : g_unpack
        assign op_arr_s[i]  = bus.req_op_i[i*OpWidth +: OpWidth];
        assign a_arr_s[i]   = bus.req_operand_a_i[i*XLEN +: XLEN];
        assign b_arr_s[i]   = bus.req_operand_b_i[i*XLEN +: XLEN];
        assign tid_arr_s[i] = bus.req_trans_id_i[i*TransIdWidth +: TransIdWidth];
    end

    // Round-robin search from rr_q, gated by a free result slot, flush and reset
    always_comb begin
        grant_en_s  = (!out_valid_q || bus.out_ready_i) && !bus.flush_i && !rst_i;
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        gnt_vec_s   = '0;
        cand_s      = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (int'(rr_q) + k >= NumReq) begin
                cand_s = IdxW'(int'(rr_q) + k - NumReq);
            end else begin
                cand_s = IdxW'(int'(rr_q) + k);
            end
            if (grant_en_s && !gnt_found_s && bus.req_valid_i[cand_s]) begin
                gnt_found_s       = 1'b1;
                gnt_idx_s         = cand_s;
                gnt_vec_s[cand_s] = 1'b1;
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // ALU operand mux; quiet zeros when nothing is granted
    always_comb begin
        alu_op_s = '0;
        alu_a_s  = '0;
        alu_b_s  = '0;
        if (gnt_found_s) begin
            alu_op_s = op_arr_s[gnt_idx_s];
            alu_a_s  = a_arr_s[gnt_idx_s];
            alu_b_s  = b_arr_s[gnt_idx_s];
        end else begin
            alu_op_s = '0;
        end
    end

    // Next pointer and result buffer; a grant replaces the entry, flush only kills it
    always_comb begin
        rr_d             = rr_q;
        out_valid_d      = out_valid_q;
        out_req_idx_d    = out_req_idx_q;
        out_trans_id_d   = out_trans_id_q;
        out_result_d     = out_result_q;
        out_branch_res_d = out_branch_res_q;
        if (gnt_found_s) begin
            rr_d             = (gnt_idx_s == IdxW'(NumReq - 1)) ? '0 : gnt_idx_s + IdxW'(1);
            out_valid_d      = 1'b1;
            out_req_idx_d    = gnt_idx_s;
            out_trans_id_d   = tid_arr_s[gnt_idx_s];
            out_result_d     = bus.alu_result_i;
            out_branch_res_d = bus.alu_branch_res_i;
        end else if (bus.flush_i || bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q             <= '0;
            out_valid_q      <= 1'b0;
            out_req_idx_q    <= '0;
            out_trans_id_q   <= '0;
            out_result_q     <= '0;
            out_branch_res_q <= 1'b0;
        end else begin
            rr_q             <= rr_d;
            out_valid_q      <= out_valid_d;
            out_req_idx_q    <= out_req_idx_d;
            out_trans_id_q   <= out_trans_id_d;
            out_result_q     <= out_result_d;
            out_branch_res_q <= out_branch_res_d;
        end
    end

    assign bus.req_ready_o      = gnt_vec_s;
    assign bus.alu_valid_o      = |gnt_vec_s;
    assign bus.alu_op_o         = alu_op_s;
    assign bus.alu_operand_a_o  = alu_a_s;
    assign bus.alu_operand_b_o  = alu_b_s;
    assign bus.out_valid_o      = out_valid_q;
    assign bus.out_req_idx_o    = out_req_idx_q;
    assign bus.out_trans_id_o   = out_trans_id_q;
    assign bus.out_result_o     = out_result_q;
    assign bus.out_branch_res_o = out_branch_res_q;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] grant_cnt_q [NumReq];
    logic [31:0] grant_cnt_d [NumReq];
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counters wrap naturally at 2^32; stall means someone asked and nobody won
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i] + {31'd0, gnt_vec_s[i]};
        end
        if ((|bus.req_valid_i) && !gnt_found_s) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumReq; i++) begin
                grant_cnt_q[i] <= 32'd0;
            end
            stall_cnt_q <= 32'd0;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    for (genvar i = 0; i < NumReq; i++) begin : g_perf
        assign perf_grant_cnt_o[i*32 +: 32] = grant_cnt_q[i];
    end
    assign perf_stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter against a transaction-level reference model.
module tb_alu_share_arbiter;
    localparam int N  = 2;
    localparam int XL = 64;
    localparam int OW = 8;
    localparam int TW = 3;
    localparam int IW = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NumReq(N), .XLEN(XL), .OpWidth(OW), .TransIdWidth(TW)) bus ();

`ifdef ALU_ARB_PERF_EN
    logic [N*32-1:0] perf_g;
    logic [31:0]     perf_s;
`endif

    alu_share_arbiter #(.NumReq(N), .XLEN(XL), .OpWidth(OW), .TransIdWidth(TW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant_cnt_o (perf_g),
        .perf_stall_cnt_o (perf_s)
`endif
    );

    // Bench-side ALU: op[1:0] selects add/sub/xor/or, branch = unsigned a<b
    function automatic logic [XL-1:0] alu_fn(input logic [OW-1:0] o, input logic [XL-1:0] x, input logic [XL-1:0] y);
        case (o[1:0])
            2'd0:    return x + y;
            2'd1:    return x - y;
            2'd2:    return x ^ y;
            default: return x | y;
        endcase
    endfunction

    assign bus.alu_result_i     = alu_fn(bus.alu_op_o, bus.alu_operand_a_o, bus.alu_operand_b_o);
    assign bus.alu_branch_res_i = (bus.alu_operand_a_o < bus.alu_operand_b_o);

    // stimulus
    logic [N-1:0]  v;
    logic [OW-1:0] op  [N];
    logic [XL-1:0] a   [N];
    logic [XL-1:0] b   [N];
    logic [TW-1:0] tid [N];
    logic          rdy;
    logic          fl;

    // reference model state
    int            m_rr;
    bit            m_valid;
    int            m_idx;
    logic [TW-1:0] m_tid;
    logic [XL-1:0] m_res;
    logic          m_br;
    int unsigned   m_gcnt [N];
    int unsigned   m_scnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic drive();
        bus.req_valid_i = v;
        bus.out_ready_i = rdy;
        bus.flush_i     = fl;
        for (int i = 0; i < N; i++) begin
            bus.req_op_i[i*OW +: OW]        = op[i];
            bus.req_operand_a_i[i*XL +: XL] = a[i];
            bus.req_operand_b_i[i*XL +: XL] = b[i];
            bus.req_trans_id_i[i*TW +: TW]  = tid[i];
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_valid = 1'b0; m_idx = 0; m_tid = '0; m_res = '0; m_br = 1'b0;
        for (int i = 0; i < N; i++) m_gcnt[i] = 0;
        m_scnt = 0;
    endtask

    // One clock: check combinational and buffered outputs, clock, advance model
    task automatic cycle();
        int g;
        logic [N-1:0]  exp_ready;
        logic [OW-1:0] exp_op;
        logic [XL-1:0] exp_a, exp_b;
        drive();
        #1;
        g = -1;
        if ((!m_valid || rdy) && !fl && !rst) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_ready = '0;
        exp_op = '0; exp_a = '0; exp_b = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            exp_op = op[g]; exp_a = a[g]; exp_b = b[g];
        end
        n_vec++;
        if (bus.req_ready_o !== exp_ready) begin
            n_err++; $display("FAIL req_ready got %b exp %b at %0t", bus.req_ready_o, exp_ready, $time);
        end
        n_vec++;
        if (bus.alu_valid_o !== (g >= 0)) begin
            n_err++; $display("FAIL alu_valid got %b exp %b at %0t", bus.alu_valid_o, (g >= 0), $time);
        end
        n_vec++;
        if (bus.alu_op_o !== exp_op || bus.alu_operand_a_o !== exp_a || bus.alu_operand_b_o !== exp_b) begin
            n_err++; $display("FAIL alu_drive got %h/%h/%h exp %h/%h/%h at %0t", bus.alu_op_o,
                              bus.alu_operand_a_o, bus.alu_operand_b_o, exp_op, exp_a, exp_b, $time);
        end
        n_vec++;
        if (bus.out_valid_o !== m_valid) begin
            n_err++; $display("FAIL out_valid got %b exp %b at %0t", bus.out_valid_o, m_valid, $time);
        end
        n_vec++;
        if (bus.out_req_idx_o !== IW'(m_idx) || bus.out_trans_id_o !== m_tid ||
            bus.out_result_o !== m_res || bus.out_branch_res_o !== m_br) begin
            n_err++; $display("FAIL out_data got %0d/%0d/%h/%b exp %0d/%0d/%h/%b at %0t",
                              bus.out_req_idx_o, bus.out_trans_id_o, bus.out_result_o, bus.out_branch_res_o,
                              m_idx, m_tid, m_res, m_br, $time);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                m_valid = 1'b1; m_idx = g; m_tid = tid[g];
                m_res = alu_fn(op[g], a[g], b[g]); m_br = (a[g] < b[g]);
                m_rr = (g + 1) % N;
                m_gcnt[g]++;
            end else begin
                if (fl || rdy) m_valid = 1'b0;
                if (|v) m_scnt++;
            end
        end
        #1;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            op[i]  = OW'($urandom_range(0, 255));
            a[i]   = {$urandom, $urandom};
            b[i]   = {$urandom, $urandom};
            tid[i] = TW'($urandom_range(0, 7));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; v = 2'b11; rdy = 1'b1; fl = 1'b0;
        rand_payload();
        cycle();
        cycle();
        n_vec++;
        if (bus.out_valid_o !== 1'b0 || bus.out_result_o !== 64'd0 || bus.out_trans_id_o !== 3'd0 ||
            bus.out_req_idx_o !== 1'b0 || bus.out_branch_res_o !== 1'b0) begin
            n_err++; $display("FAIL reset_state got v=%b r=%h t=%0d", bus.out_valid_o, bus.out_result_o, bus.out_trans_id_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_alternate();
        v = 2'b11; rdy = 1'b1; fl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rand_payload();
            cycle();
            n_vec++;
            if (bus.out_valid_o !== 1'b1 || bus.out_req_idx_o !== IW'(i % 2)) begin
                n_err++; $display("FAIL alternate[%0d] got v=%b idx=%0d exp v=1 idx=%0d", i,
                                  bus.out_valid_o, bus.out_req_idx_o, i % 2);
            end
        end
    endtask

    task automatic test_add();
        v = 2'b01; rdy = 1'b1; fl = 1'b0;
        rand_payload();
        op[0] = 8'd0; a[0] = 64'd5; b[0] = 64'd7; tid[0] = 3'd3;
        cycle();
        n_vec++;
        if (bus.out_result_o !== 64'd12 || bus.out_trans_id_o !== 3'd3 ||
            bus.out_req_idx_o !== 1'b0 || bus.out_valid_o !== 1'b1) begin
            n_err++; $display("FAIL add got r=%0d t=%0d i=%0d v=%b exp 12/3/0/1", bus.out_result_o,
                              bus.out_trans_id_o, bus.out_req_idx_o, bus.out_valid_o);
        end
    endtask

    task automatic test_hold();
        logic [XL-1:0] held;
        v = 2'b00; rdy = 1'b1; fl = 1'b0;
        cycle();
        v = 2'b01; rdy = 1'b0; rand_payload();
        cycle();
        held = bus.out_result_o;
        v = 2'b10;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_vec++;
            if (bus.out_valid_o !== 1'b1 || bus.out_result_o !== held || bus.out_req_idx_o !== 1'b0) begin
                n_err++; $display("FAIL hold[%0d] got v=%b r=%h exp v=1 r=%h", i, bus.out_valid_o, bus.out_result_o, held);
            end
        end
        rdy = 1'b1;
        cycle();
        n_vec++;
        if (bus.out_valid_o !== 1'b1 || bus.out_req_idx_o !== 1'b1 ||
            bus.out_result_o !== alu_fn(op[1], a[1], b[1])) begin
            n_err++; $display("FAIL hold_release got v=%b idx=%0d exp v=1 idx=1", bus.out_valid_o, bus.out_req_idx_o);
        end
    endtask

    task automatic test_flush();
        v = 2'b01; rdy = 1'b0; fl = 1'b1;
        cycle();
        n_vec++;
        if (bus.out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL flush_kill got v=%b exp 0", bus.out_valid_o);
        end
        fl = 1'b0; v = 2'b11; rdy = 1'b1; rand_payload();
        cycle();
        n_vec++;
        if (bus.out_valid_o !== 1'b1 || bus.out_req_idx_o !== 1'b0) begin
            n_err++; $display("FAIL flush_rr got v=%b idx=%0d exp v=1 idx=0", bus.out_valid_o, bus.out_req_idx_o);
        end
    endtask

    task automatic test_reset_mid();
        v = 2'b11; rdy = 1'b0; rst = 1'b1; rand_payload();
        cycle();
        n_vec++;
        if (bus.out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL reset_mid got v=%b exp 0", bus.out_valid_o);
        end
        rst = 1'b0; rdy = 1'b1; rand_payload();
        cycle();
        n_vec++;
        if (bus.out_req_idx_o !== 1'b0 || bus.out_valid_o !== 1'b1) begin
            n_err++; $display("FAIL reset_rr got idx=%0d v=%b exp idx=0 v=1", bus.out_req_idx_o, bus.out_valid_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            v   = N'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 99) == 0);
            rand_payload();
            cycle();
        end
        rst = 1'b0; fl = 1'b0;
    endtask

`ifdef ALU_ARB_PERF_EN
    task automatic test_perf();
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (perf_g[i*32 +: 32] !== m_gcnt[i]) begin
                n_err++; $display("FAIL perf_grant[%0d] got %0d exp %0d", i, perf_g[i*32 +: 32], m_gcnt[i]);
            end
        end
        n_vec++;
        if (perf_s !== m_scnt) begin
            n_err++; $display("FAIL perf_stall got %0d exp %0d", perf_s, m_scnt);
        end
    endtask
`endif

    initial begin
        v = '0; rdy = 1'b0; fl = 1'b0;
        rand_payload();
        drive();
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_alternate();
        test_add();
        test_hold();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef ALU_ARB_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one integer ALU instance between NumReq requesters, e.g. the main issue port and a secondary branch/bitmanip issue port.
- Arbitration is round-robin. The arbiter drives the ALU's combinational inputs from the granted requester.
- It captures the ALU result and branch result into a single-entry output register, which uses valid/ready back-pressure.
- Result latency is exactly one cycle after the request handshake. Throughput is one operation per cycle when the consumer never stalls.

Parameters:
NumReq, 2, number of requesters (1..8)
XLEN, 64, operand/result width
OpWidth, 8, width of the ALU operation code (fu_op encoding)
TransIdWidth, 3, width of the scoreboard transaction id carried alongside each op

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  pipeline flush; kills the buffered result and blocks grants this cycle
req_valid_i  in  NumReq  per-requester request valid
req_ready_o  out  NumReq  per-requester grant (one-hot or zero)
req_op_i  in  NumReq*OpWidth  per-requester operation code
req_operand_a_i  in  NumReq*XLEN  per-requester operand a
req_operand_b_i  in  NumReq*XLEN  per-requester operand b
req_trans_id_i  in  NumReq*TransIdWidth  per-requester transaction id
alu_valid_o  out  1  ALU inputs carry a granted op this cycle
alu_op_o  out  OpWidth  to ALU operation
alu_operand_a_o  out  XLEN  to ALU operand a
alu_operand_b_o  out  XLEN  to ALU operand b
alu_result_i  in  XLEN  combinational ALU result
alu_branch_res_i  in  1  combinational ALU branch comparison result
out_valid_o  out  1  buffered result valid
out_ready_i  in  1  consumer accepts result
out_req_idx_o  out  max(1,$clog2(NumReq))  index of the requester that issued the result
out_trans_id_o  out  TransIdWidth  transaction id of the result
out_result_o  out  XLEN  buffered ALU result
out_branch_res_o  out  1  buffered branch result

Behaviour:
- Reset (rst_i high at a clock edge):
  - out_valid_o=0; all out_* data=0.
  - Round-robin pointer rr_q=0.
  - Optional counters=0.
  - A reset mid-operation discards the buffered result with no handshake.
- Slot-free condition:
  - slot_free = !out_valid_q || out_ready_i.
  - A grant is allowed only when slot_free && !flush_i && !rst_i.
- Arbitration:
  - Pick the first requester with req_valid_i set, searching from index rr_q upward and wrapping modulo NumReq.
  - req_ready_o is one-hot on the winner, zero otherwise. It is combinational from req_valid_i, rr_q, out_valid_q, out_ready_i and flush_i.
  - Requesters must hold valid and payload stable until ready. The block does not depend on this, since it samples on the handshake.
- Pointer update: on a grant to index g, rr_q <= (g+1) mod NumReq. With no grant, rr_q is unchanged, including on flush.
- ALU drive:
  - alu_valid_o = |req_ready_o.
  - alu_op/operands are muxed from the granted requester.
  - With no grant, all alu_* outputs are 0.
- Capture:
  - On a grant edge: out_valid_q<=1, and out_result/out_branch_res <= alu_result_i/alu_branch_res_i.
  - out_req_idx<=g; out_trans_id<=the granted requester's req_trans_id_i.
  - Result appears on out_* exactly one cycle after the handshake.
- Hold: while out_valid_o && !out_ready_i, all out_* stay stable and no grant is issued.
- Drain: out_ready_i with no new grant gives out_valid_q<=0. Data registers retain their old value; they are don't-care.
- Back-to-back: out_ready_i plus a new grant in the same cycle replaces the buffer, so out_valid stays 1.
- flush_i:
  - At the edge, out_valid_q<=0, overriding any capture.
  - req_ready_o=0 in the same cycle.
  - A result consumed in the same cycle as the flush still counts as accepted by the consumer.
- NumReq=1: pointer is constant 0 and out_req_idx_o is constant 0.

Optional Feature:
ALU_ARB_PERF_EN:
- Defined: adds outputs perf_grant_cnt_o (NumReq*32) and perf_stall_cnt_o (32).
  - perf_grant_cnt[i] increments on each grant to requester i.
  - perf_stall_cnt increments every cycle with |req_valid_i && !(|req_ready_o), flush cycles included.
  - Counters wrap at 2^32 and are cleared only by rst_i.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then both requesters valid every cycle with out_ready_i=1 → grants alternate 0,1,0,1. out_valid_o is continuously 1 from the cycle after the first grant. out_req_idx_o follows 0,1,0,1 one cycle behind.
- Req0 issues op=ADD, a=5, b=7, trans_id=3 → next cycle out_result_o=12, out_trans_id_o=3, out_req_idx_o=0, out_valid_o=1.
- Hold out_ready_i=0 for 4 cycles with a result buffered and req1 valid → req_ready_o=0 throughout and out_* stable. On the cycle out_ready_i=1, req1 is granted, and its result appears the following cycle with no bubble.
- Assert flush_i while out_valid_o=1 and req0 is valid → req_ready_o=0 that cycle. out_valid_o=0 next cycle. rr_q is unchanged, so req0 wins the following cycle.
- Apply rst_i mid-stream with a buffered result and rr_q=1 → next cycle out_valid_o=0. The first subsequent simultaneous request grants requester 0.
- With ALU_ARB_PERF_EN: 10 grants to req0, 6 to req1, 3 blocked cycles → perf_grant_cnt = {6,10}, perf_stall_cnt = 3. Preload the counter to 0xFFFFFFFF and grant once → it wraps to 0.
